// File: rtl/counter_sequencer.sv
// Two-requester command sequencer driving clear/load/increment/decrement pulses to a shared
// counter. It grants round-robin on contention, and a command can be aborted while it runs.
module counter_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_cmd,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_cmd,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             abort,
  output logic             cnt_clr,
  output logic             cnt_load,
  output logic             cnt_inc,
  output logic             cnt_dec,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             busy,
  output logic             done,
  output logic             done_src,
  output logic             done_abort
);

  localparam logic [1:0] CmdClear = 2'b00;
  localparam logic [1:0] CmdLoad  = 2'b01;
  localparam logic [1:0] CmdUp    = 2'b10;

  typedef enum logic {StIdle, StExec} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       cmd_q, cmd_d;
  // Holds the load value for LOAD, or the remaining pulse count for UP/DOWN.
  logic [WIDTH-1:0] data_q, data_d;
  logic             src_q, src_d;

  logic any_valid;
  logic gnt_src;
  logic finish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cmd_q        <= 2'b00;
      data_q       <= '0;
      src_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      src_q        <= src_d;
    end
  end

  assign any_valid = req0_valid | req1_valid;
  // Contention goes to whoever was not granted last; otherwise the lone requester wins.
  assign gnt_src   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    src_d        = src_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    busy         = 1'b0;
    done         = 1'b0;
    done_src     = 1'b0;
    done_abort   = 1'b0;
    finish       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rst && any_valid) begin
          req0_ready   = ~gnt_src;
          req1_ready   = gnt_src;
          state_d      = StExec;
          cmd_d        = gnt_src ? req1_cmd : req0_cmd;
          data_d       = gnt_src ? req1_data : req0_data;
          src_d        = gnt_src;
          last_grant_d = gnt_src;
        end
      end
      StExec: begin
        if (!rst) begin
          busy = 1'b1;
          if (abort) begin
            finish     = 1'b1;
            done_abort = 1'b1;
          end else begin
            case (cmd_q)
              CmdClear: begin
                cnt_clr = 1'b1;
                finish  = 1'b1;
              end
              CmdLoad: begin
                cnt_load     = 1'b1;
                cnt_load_val = data_q;
                finish       = 1'b1;
              end
              default: begin
                if (data_q == '0) begin
                  finish = 1'b1;
                end else begin
                  cnt_inc = (cmd_q == CmdUp);
                  cnt_dec = (cmd_q != CmdUp);
                  data_d  = data_q - WIDTH'(1);
                  finish  = (data_q == WIDTH'(1));
                end
              end
            endcase
          end
          if (finish) begin
            done     = 1'b1;
            done_src = src_q;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a transaction-level model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_counter_sequencer;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]   req0_cmd = 2'b00, req1_cmd = 2'b00;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         abort = 1'b0;
  logic         req0_ready, req1_ready;
  logic         cnt_clr, cnt_load, cnt_inc, cnt_dec;
  logic [W-1:0] cnt_load_val;
  logic         busy, done, done_src, done_abort;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .abort(abort),
    .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec),
    .cnt_load_val(cnt_load_val),
    .busy(busy), .done(done), .done_src(done_src), .done_abort(done_abort)
  );

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: an accepted job is (cmd, value, source) plus how many pulses it has issued so far.
  bit         m_busy = 1'b0;
  bit         m_last = 1'b1;
  logic [1:0] m_cmd = 2'b00;
  logic [W-1:0] m_data = '0;
  int         m_sent = 0;
  bit         m_src = 1'b0;
  logic e_r0, e_r1, e_clr, e_load, e_inc, e_dec, e_busy, e_done, e_src, e_ab;
  logic [W-1:0] e_val;

  always @(negedge clk) begin
    {e_r0, e_r1, e_clr, e_load, e_inc, e_dec, e_busy, e_done, e_src, e_ab} = '0;
    e_val = '0;
    if (!rst) begin
      if (!m_busy) begin
        e_r0 = req0_valid && (!req1_valid || m_last);
        e_r1 = req1_valid && (!req0_valid || !m_last);
      end else begin
        e_busy = 1'b1;
        if (abort) begin
          e_done = 1'b1;
          e_ab   = 1'b1;
        end else if (m_cmd == 2'b00) begin
          e_clr  = 1'b1;
          e_done = 1'b1;
        end else if (m_cmd == 2'b01) begin
          e_load = 1'b1;
          e_val  = m_data;
          e_done = 1'b1;
        end else if (int'(m_data) == 0) begin
          e_done = 1'b1;
        end else begin
          e_inc  = (m_cmd == 2'b10);
          e_dec  = (m_cmd == 2'b11);
          e_done = (m_sent + 1 == int'(m_data));
        end
        e_src = e_done & m_src;
      end
    end

    cmp("req0_ready", req0_ready, e_r0);
    cmp("req1_ready", req1_ready, e_r1);
    cmp("cnt_clr", cnt_clr, e_clr);
    cmp("cnt_load", cnt_load, e_load);
    cmp("cnt_inc", cnt_inc, e_inc);
    cmp("cnt_dec", cnt_dec, e_dec);
    cmp("cnt_load_val", cnt_load_val, e_val);
    cmp("busy", busy, e_busy);
    cmp("done", done, e_done);
    cmp("done_src", done_src, e_src);
    cmp("done_abort", done_abort, e_ab);
    cmp("ready_exclusive", req0_ready & req1_ready, 0);
    cmp("pulse_onehot", $countones({cnt_clr, cnt_load, cnt_inc, cnt_dec}) <= 1, 1);

    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (!m_busy) begin
      if ((e_r0 && req0_valid) || (e_r1 && req1_valid)) begin
        m_busy = 1'b1;
        m_src  = e_r1;
        m_last = e_r1;
        m_cmd  = e_r1 ? req1_cmd : req0_cmd;
        m_data = e_r1 ? req1_data : req0_data;
        m_sent = 0;
      end
    end else if (e_done) begin
      m_busy = 1'b0;
    end else begin
      m_sent++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [1:0] c, input logic [W-1:0] d);
    req0_valid = v; req0_cmd = c; req0_data = d;
  endtask

  task automatic set1(input logic v, input logic [1:0] c, input logic [W-1:0] d);
    req1_valid = v; req1_cmd = c; req1_data = d;
  endtask

  int pulses;
  int dones;
  int done_at;

  initial begin
    // Reset with a valid request pending: reset wins, nothing is accepted.
    set0(1'b1, 2'b01, 8'h11);
    mid();  cmp("rst_prio_ready0", req0_ready, 0);
    tick(); mid(); tick();
    rst = 1'b0; req0_valid = 1'b0;
    mid();  cmp("reset_busy", busy, 0);
    tick();

    // Single LOAD, then a back-to-back second LOAD.
    set0(1'b1, 2'b01, 8'h5A);
    mid();  cmp("s_load_ready", req0_ready, 1);
    tick(); req0_data = 8'h33;
    mid();  cmp("s_load_pulse", cnt_load, 1); cmp("s_load_val", cnt_load_val, 8'h5A);
    cmp("s_load_done", done, 1); cmp("s_load_src", done_src, 0);
    tick();
    mid();  cmp("s_load_ready_again", req0_ready, 1);
    tick(); req0_valid = 1'b0;
    mid();  cmp("s_load2_val", cnt_load_val, 8'h33);
    tick(); mid(); tick();

    rst = 1'b1; tick(); rst = 1'b0;

    // Contention: req0 UP 3 wins first, then req1 DOWN 2.
    set0(1'b1, 2'b10, 8'd3); set1(1'b1, 2'b11, 8'd2);
    mid();  cmp("s_rr_ready0", req0_ready, 1); cmp("s_rr_ready1", req1_ready, 0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      mid(); cmp("s_rr_inc", cnt_inc, 1); tick();
    end
    mid();  cmp("s_rr_ready1_t4", req1_ready, 1); cmp("s_rr_ready0_t4", req0_ready, 0);
    tick();
    mid();  cmp("s_rr_dec_t5", cnt_dec, 1); tick();
    mid();  cmp("s_rr_dec_t6", cnt_dec, 1); cmp("s_rr_done_t6", done, 1);
    cmp("s_rr_src_t6", done_src, 1);
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    mid(); tick();

    // UP with N=0.
    set0(1'b1, 2'b10, 8'd0);
    mid(); tick(); req0_valid = 1'b0;
    mid();  cmp("s_n0_busy", busy, 1); cmp("s_n0_done", done, 1); cmp("s_n0_inc", cnt_inc, 0);
    tick();
    mid();  cmp("s_n0_idle", busy, 0); tick();

    // DOWN 10 from req1 (abort held in IDLE is ignored), aborted on the 4th EXEC cycle.
    set1(1'b1, 2'b11, 8'd10); abort = 1'b1;
    mid();  cmp("s_ab_ready1", req1_ready, 1);
    tick(); abort = 1'b0; req1_valid = 1'b0; set0(1'b1, 2'b00, 8'd0);
    pulses = 0;
    for (int k = 1; k <= 3; k++) begin
      mid(); pulses += int'(cnt_dec); tick();
      if (k == 2) req0_valid = 1'b0;
    end
    abort = 1'b1;
    mid();  cmp("s_ab_done", done, 1); cmp("s_ab_flag", done_abort, 1);
    cmp("s_ab_dec", cnt_dec, 0); cmp("s_ab_src", done_src, 1);
    tick(); abort = 1'b0;
    mid();  cmp("s_ab_pulses", pulses, 3); cmp("s_ab_idle", busy, 0);
    tick();

    // Abort on what would be the final pulse of UP 2.
    set0(1'b1, 2'b10, 8'd2);
    mid(); tick(); req0_valid = 1'b0;
    mid();  cmp("s_ablast_inc1", cnt_inc, 1); tick(); abort = 1'b1;
    mid();  cmp("s_ablast_inc2", cnt_inc, 0); cmp("s_ablast_abort", done_abort, 1);
    tick(); abort = 1'b0;

    // Full-range UP 255: exactly 255 pulses, done on the last one.
    set0(1'b1, 2'b10, 8'd255);
    mid(); tick(); req0_valid = 1'b0;
    pulses = 0; done_at = 0;
    for (int k = 1; k <= 300; k++) begin
      mid(); pulses += int'(cnt_inc);
      if (done) begin
        done_at = k;
        break;
      end
      tick();
    end
    cmp("s_full_pulses", pulses, 255); cmp("s_full_done_at", done_at, 255);
    tick();

    // UP 255 cancelled by reset on the 100th pulse cycle.
    set0(1'b1, 2'b10, 8'd255);
    mid(); tick(); req0_valid = 1'b0;
    pulses = 0; dones = 0;
    for (int k = 1; k <= 99; k++) begin
      mid(); pulses += int'(cnt_inc); dones += int'(done); tick();
    end
    rst = 1'b1;
    mid();  cmp("s_rst_inc", cnt_inc, 0); cmp("s_rst_done", done, 0);
    tick(); rst = 1'b0; set1(1'b1, 2'b01, 8'hA5);
    mid();  cmp("s_rst_pulses", pulses, 99); cmp("s_rst_dones", dones, 0);
    cmp("s_rst_busy", busy, 0); cmp("s_rst_ready1", req1_ready, 1);
    tick(); req1_valid = 1'b0;
    mid();  cmp("s_rst_load_val", cnt_load_val, 8'hA5); cmp("s_rst_load_src", done_src, 1);
    tick(); mid(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, width of counter load value and repeat count.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a command.
REQ-005 req0_cmd  input  2  00 CLEAR, 01 LOAD, 10 UP, 11 DOWN.
REQ-006 req0_data  input  WIDTH  LOAD value, or repeat count N for UP/DOWN.
REQ-007 req0_ready  output  1  requester 0 command accepted this cycle when valid also high.
REQ-008 req1_valid, req1_cmd, req1_data, req1_ready SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 abort  input  1  terminate the executing command.
REQ-010 cnt_clr, cnt_load, cnt_inc, cnt_dec  output  1 each  one-cycle control pulses to the shared counter.
REQ-011 cnt_load_val  output  WIDTH  load value; meaningful only while cnt_load=1, otherwise 0.
REQ-012 busy  output  1  FSM in EXEC.
REQ-013 done, done_src, done_abort  output  1 each  completion pulse, requester index, aborted flag.

Function
REQ-014 FSM SHALL have two states: IDLE, EXEC.
REQ-015 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high.
REQ-016 Grant: only one valid -> that requester; both valid -> requester not granted last (round-robin); none -> no grant.
REQ-017 last_grant SHALL update only on acceptance (valid && ready).
REQ-018 Acceptance at cycle T SHALL latch cmd, data, source and move FSM to EXEC at T+1.
REQ-019 Inputs not accepted SHALL not affect state; a requester may drop valid before acceptance without effect.
REQ-020 CLEAR: EXEC one cycle, cnt_clr=1, done=1.
REQ-021 LOAD: EXEC one cycle, cnt_load=1, cnt_load_val=latched data, done=1.
REQ-022 UP/DOWN with N>0: cnt_inc (or cnt_dec) high for exactly N consecutive cycles T+1..T+N; done=1 on cycle T+N.
REQ-023 UP/DOWN with N=0: EXEC one cycle, no pulse, done=1.
REQ-024 N=2^WIDTH-1 SHALL produce exactly 2^WIDTH-1 pulses (no wrap of remaining count).
REQ-025 After done, FSM SHALL return to IDLE next cycle; next acceptance earliest at T+max(N,1)+1.
REQ-026 abort high in EXEC: no control pulse that cycle, done=1, done_abort=1, return to IDLE next cycle.
REQ-027 abort in IDLE SHALL be ignored; abort on what would be the last cycle still suppresses that pulse.
REQ-028 done_src SHALL equal latched source whenever done=1; done_src, done_abort SHALL be 0 when done=0.
REQ-029 At most one of cnt_clr, cnt_load, cnt_inc, cnt_dec SHALL be high in any cycle.

Reset
REQ-030 rst=1 SHALL force IDLE, all outputs 0, remaining count 0, last_grant=1 (requester 0 wins first contention).
REQ-031 rst during EXEC SHALL cancel the command with no done pulse; outputs 0 from the cycle after the reset edge.
REQ-032 rst SHALL take priority over acceptance and abort in the same cycle.

Verification
REQ-033 Reset, req0 LOAD 0x5A -> req0_ready=1 at T, cnt_load=1 with cnt_load_val=0x5A and done=1, done_src=0 at T+1, ready again T+2.
REQ-034 Both valid continuously, req0 UP N=3, req1 DOWN N=2 -> req0 granted first, cnt_inc T+1..T+3, req1 accepted T+4, cnt_dec T+5..T+6, done_src=1 at T+6.
REQ-035 UP N=0 -> no pulses, busy one cycle, done=1 at T+1.
REQ-036 DOWN N=10, abort at 4th EXEC cycle -> exactly 3 cnt_dec pulses, done=1 and done_abort=1 on 4th cycle.
REQ-037 UP N=255 (WIDTH=8), rst asserted at 100th pulse -> 99 pulses observed, no done, all outputs 0 and ready to accept after reset released.
REQ-038 Every scenario SHALL check REQ-015 and REQ-029 each cycle.
